// File: rtl/mmio_pkg.sv
// Shared constants for the IO-window responder: register selects,
// status bit positions and the address tag that routes to this block.
package mmio_pkg;

  // Register select values (address[2:0]) inside the IO window.
  typedef enum logic [2:0] {
    SEL_DATA = 3'd0,
    SEL_STAT = 3'd1,
    SEL_HALT = 3'd4
  } sel_e;

  // Bit positions inside the status byte.
  localparam int unsigned RXNE = 0;
  localparam int unsigned TXF  = 1;
  localparam int unsigned OVF  = 2;

  // Address bits [17:16] value that selects the IO window.
  localparam logic [1:0] IO_WINDOW = 2'b11;

  // True when a full bus address falls inside the IO window.
  function automatic logic is_io_addr(input logic [17:0] addr);
    return addr[17:16] == IO_WINDOW;
  endfunction

  // Assemble the status byte from its individual flags.
  function automatic logic [7:0] status_byte(input logic ovf,
                                             input logic txf,
                                             input logic rxne);
    logic [7:0] s;
    s       = '0;
    s[OVF]  = ovf;
    s[TXF]  = txf;
    s[RXNE] = rxne;
    return s;
  endfunction

endpackage

// File: rtl/mmio_responder_byte_fifo.sv
// First-word-fall-through byte FIFO with 2**AW entries.
// A push while full is accepted only when a pop happens in the same cycle;
// a pop while empty is ignored.
module byte_fifo #(
  parameter int unsigned AW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [7:0]    din_i,
  output logic [7:0]    dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Occupancy next-state: simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; pointers wrap modulo depth.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/mmio_responder.sv
// Byte-wide bus responder for the IO window: character output through a
// TX FIFO, character input through an RX FIFO, status and program halt.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int unsigned TX_AW = 4,
  parameter int unsigned RX_AW = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  input  logic       en_in,
  input  logic       wr_in,
  input  logic [2:0] sel_in,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       stall_out,
  output logic       halt_out,
  output logic [7:0] tx_data_out,
  output logic       tx_valid_out,
  input  logic       tx_ready_in,
  input  logic [7:0] rx_data_in,
  input  logic       rx_valid_in
);

  localparam int unsigned TX_DEPTH = 1 << TX_AW;
  localparam int unsigned RX_DEPTH = 1 << RX_AW;

  logic           acc;
  logic           rd_acc;
  logic           wr_acc;
  logic           tx_wr_req;

  logic           tx_push;
  logic           tx_pop;
  logic           tx_full;
  logic           tx_empty;
  logic [TX_AW:0] tx_count;

  logic           rx_pop;
  logic           rx_full;
  logic           rx_empty;
  logic [7:0]     rx_head;
  logic [RX_AW:0] rx_count;

  logic           ovf_set;
  logic           ovf_clr;

  logic [7:0]     d_q;
  logic           halt_q;
  logic           ovf_q;

  assign acc       = rdy_in & en_in;
  assign rd_acc    = acc & ~wr_in;
  assign wr_acc    = acc &  wr_in;
  assign tx_wr_req = wr_acc & (sel_in == SEL_DATA);

  // A full TX FIFO stalls even if the transmitter pops this cycle.
  assign stall_out = tx_wr_req & tx_full;
  assign tx_push   = tx_wr_req & ~tx_full;
  assign tx_pop    = ~tx_empty & tx_ready_in;

  assign rx_pop    = rd_acc & (sel_in == SEL_DATA) & ~rx_empty;
  assign ovf_set   = rx_valid_in & rx_full & ~rx_pop;
  assign ovf_clr   = wr_acc & (sel_in == SEL_STAT) & d_in[OVF];

  assign d_out        = d_q;
  assign halt_out     = halt_q;
  assign tx_valid_out = ~tx_empty;

  byte_fifo #(.AW(TX_AW)) u_tx_fifo (
    .clk_i   (clk_in),
    .rst_ni  (rst_in),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .din_i   (d_in),
    .dout_o  (tx_data_out),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  byte_fifo #(.AW(RX_AW)) u_rx_fifo (
    .clk_i   (clk_in),
    .rst_ni  (rst_in),
    .push_i  (rx_valid_in),
    .pop_i   (rx_pop),
    .din_i   (rx_data_in),
    .dout_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  // Register decode: read data, sticky halt and RX overflow flag.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      d_q    <= '0;
      halt_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (rd_acc) begin
        case (sel_in)
          SEL_DATA: d_q <= rx_empty ? 8'h00 : rx_head;
          SEL_STAT: d_q <= status_byte(ovf_q, tx_full, ~rx_empty);
          default:  d_q <= '0;
        endcase
      end
      if (wr_acc && (sel_in == SEL_HALT)) halt_q <= 1'b1;
      // A fresh overflow wins over a clear in the same cycle.
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  // Occupancy must stay consistent with the FIFO full/empty flags.
  a_tx_count: assert property (@(posedge clk_in) disable iff (!rst_in)
    (tx_count <= (TX_AW+1)'(TX_DEPTH)) &&
    ((tx_count == '0) == tx_empty) &&
    ((tx_count == (TX_AW+1)'(TX_DEPTH)) == tx_full));

  a_rx_count: assert property (@(posedge clk_in) disable iff (!rst_in)
    (rx_count <= (RX_AW+1)'(RX_DEPTH)) &&
    ((rx_count == '0) == rx_empty) &&
    ((rx_count == (RX_AW+1)'(RX_DEPTH)) == rx_full));

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_mmio_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       rdy;
  logic       en;
  logic       wr;
  logic [2:0] sel;
  logic [7:0] din;
  logic [7:0] dout;
  logic       stall;
  logic       halt;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  byte unsigned tx_q[$];
  byte unsigned rx_q[$];
  bit           m_ovf;
  bit           m_halt;
  logic [7:0]   m_dout;

  always #5 clk = ~clk;

  mmio_responder #(.TX_AW(4), .RX_AW(4)) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .rdy_in       (rdy),
    .en_in        (en),
    .wr_in        (wr),
    .sel_in       (sel),
    .d_in         (din),
    .d_out        (dout),
    .stall_out    (stall),
    .halt_out     (halt),
    .tx_data_out  (tx_data),
    .tx_valid_out (tx_valid),
    .tx_ready_in  (tx_ready),
    .rx_data_in   (rx_data),
    .rx_valid_in  (rx_valid)
  );

  // Model one clock edge from the inputs currently driven.
  function automatic void model_edge();
    int  tx_n, rx_n;
    bit  acc, rd, wq, rx_pop, tx_push, tx_pop, ovf_set;
    if (!rst) begin
      tx_q.delete(); rx_q.delete();
      m_ovf = 0; m_halt = 0; m_dout = 8'h00;
      return;
    end
    tx_n = tx_q.size();
    rx_n = rx_q.size();
    acc  = rdy && en;
    rd   = acc && !wr;
    wq   = acc && wr;
    if (rd) begin
      if (sel == 3'd0)      m_dout = (rx_n > 0) ? rx_q[0] : 8'h00;
      else if (sel == 3'd1) m_dout = 8'(int'(m_ovf) * 4 + int'(tx_n == 16) * 2 + int'(rx_n != 0));
      else                  m_dout = 8'h00;
    end
    rx_pop  = rd && sel == 3'd0 && rx_n > 0;
    tx_push = wq && sel == 3'd0 && tx_n < 16;
    tx_pop  = tx_n > 0 && tx_ready;
    ovf_set = rx_valid && rx_n == 16 && !rx_pop;
    if (tx_pop)  void'(tx_q.pop_front());
    if (tx_push) tx_q.push_back(din);
    if (rx_pop)  void'(rx_q.pop_front());
    if (rx_valid && !ovf_set) rx_q.push_back(rx_data);
    if (wq && sel == 3'd1 && din[2]) m_ovf = 0;
    if (ovf_set) m_ovf = 1;
    if (wq && sel == 3'd4) m_halt = 1;
  endfunction

  // Advance one clock: inputs change only on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b1; rdy = 1'b1; en = 1'b0; wr = 1'b0; sel = 3'd0; din = 8'h00;
    rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  task automatic bus_wr(input logic [2:0] s, input logic [7:0] d);
    en = 1'b1; wr = 1'b1; sel = s; din = d;
  endtask

  task automatic bus_rd(input logic [2:0] s);
    en = 1'b1; wr = 1'b0; sel = s; din = 8'h00;
  endtask

  task automatic test_reset();
    idle(); tx_ready = 1'b0; rst = 1'b0;
    step(); step();
    rst = 1'b1;
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", dout); end
    checks++; if (halt !== 1'b0) begin failures++; $display("FAIL reset_halt got=%b exp=0", halt); end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_txvalid got=%b exp=0", tx_valid); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
  endtask

  task automatic test_tx_write();
    idle(); tx_ready = 1'b1;
    bus_wr(3'd0, 8'h41); #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL txw_stall0 got=%b exp=0", stall); end
    step();
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin failures++; $display("FAIL txw_first got=%b/%h exp=1/41", tx_valid, tx_data); end
    bus_wr(3'd0, 8'h42); #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL txw_stall1 got=%b exp=0", stall); end
    step();
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h42) begin failures++; $display("FAIL txw_second got=%b/%h exp=1/42", tx_valid, tx_data); end
    idle(); step();
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL txw_drained got=%b exp=0", tx_valid); end
  endtask

  task automatic test_tx_full();
    logic [7:0] exp[17];
    idle(); tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp[i] = 8'($urandom);
      bus_wr(3'd0, exp[i]); #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL txf_fill_stall i=%0d got=%b exp=0", i, stall); end
      step();
    end
    exp[16] = 8'h5A;
    bus_wr(3'd0, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL txf_stall i=%0d got=%b exp=1", i, stall); end
      step();
    end
    tx_ready = 1'b1; #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL txf_stall_with_pop got=%b exp=1", stall); end
    checks++; if (tx_data !== exp[0]) begin failures++; $display("FAIL txf_head0 got=%h exp=%h", tx_data, exp[0]); end
    step();
    tx_ready = 1'b0; #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL txf_release got=%b exp=0", stall); end
    step();
    idle(); tx_ready = 1'b1;
    for (int k = 1; k < 17; k++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp[k]) begin
        failures++; $display("FAIL txf_drain k=%0d got=%b/%h exp=1/%h", k, tx_valid, tx_data, exp[k]);
      end
      step();
    end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL txf_empty got=%b exp=0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_rx_basic();
    idle();
    bus_rd(3'd0); step();
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL rx_empty_read got=%h exp=00", dout); end
    idle(); rx_valid = 1'b1; rx_data = 8'h37; step();
    idle(); bus_rd(3'd1); step();
    checks++; if (dout !== 8'h01) begin failures++; $display("FAIL rx_stat_ne got=%h exp=01", dout); end
    bus_rd(3'd0); step();
    checks++; if (dout !== 8'h37) begin failures++; $display("FAIL rx_data got=%h exp=37", dout); end
    bus_rd(3'd1); step();
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL rx_stat_empty got=%h exp=00", dout); end
    idle(); step();
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL rx_dout_hold got=%h exp=00", dout); end
  endtask

  task automatic test_rx_overflow();
    logic [7:0] b[17];
    idle();
    for (int i = 0; i < 17; i++) begin
      b[i] = 8'($urandom);
      rx_valid = 1'b1; rx_data = b[i]; step();
    end
    idle(); bus_rd(3'd1); step();
    checks++; if (dout !== 8'h05) begin failures++; $display("FAIL ovf_stat got=%h exp=05", dout); end
    bus_wr(3'd1, 8'h04); step();
    bus_rd(3'd1); step();
    checks++; if (dout !== 8'h01) begin failures++; $display("FAIL ovf_clear got=%h exp=01", dout); end
    for (int i = 0; i < 16; i++) begin
      bus_rd(3'd0); step();
      checks++; if (dout !== b[i]) begin failures++; $display("FAIL ovf_order i=%0d got=%h exp=%h", i, dout, b[i]); end
    end
    bus_rd(3'd1); step();
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL ovf_lost17 got=%h exp=00", dout); end
    idle();
  endtask

  task automatic test_boundary();
    logic [7:0] b[17];
    idle();
    for (int i = 0; i < 16; i++) begin
      b[i] = 8'($urandom);
      rx_valid = 1'b1; rx_data = b[i]; step();
    end
    b[16] = 8'($urandom);
    bus_rd(3'd0); rx_valid = 1'b1; rx_data = b[16]; step();
    checks++; if (dout !== b[0]) begin failures++; $display("FAIL bnd_pop_push got=%h exp=%h", dout, b[0]); end
    rx_valid = 1'b0;
    bus_rd(3'd1); step();
    checks++; if (dout !== 8'h01) begin failures++; $display("FAIL bnd_no_ovf got=%h exp=01", dout); end
    for (int i = 1; i < 17; i++) begin
      bus_rd(3'd0); step();
      checks++; if (dout !== b[i]) begin failures++; $display("FAIL bnd_order i=%0d got=%h exp=%h", i, dout, b[i]); end
    end
    bus_rd(3'd1); step();
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL bnd_empty got=%h exp=00", dout); end
    idle(); rdy = 1'b0; tx_ready = 1'b0;
    bus_wr(3'd0, 8'h99); #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL bnd_rdy0_stall got=%b exp=0", stall); end
    step();
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL bnd_rdy0_push got=%b exp=0", tx_valid); end
    bus_wr(3'd4, 8'h01); step();
    checks++; if (halt !== 1'b0) begin failures++; $display("FAIL bnd_rdy0_halt got=%b exp=0", halt); end
    idle();
  endtask

  task automatic test_halt_reset();
    idle(); tx_ready = 1'b0;
    bus_wr(3'd4, 8'h00); step();
    checks++; if (halt !== 1'b1) begin failures++; $display("FAIL halt_set got=%b exp=1", halt); end
    bus_wr(3'd0, 8'h11); step();
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin failures++; $display("FAIL halt_no_block got=%b/%h exp=1/11", tx_valid, tx_data); end
    checks++; if (halt !== 1'b1) begin failures++; $display("FAIL halt_sticky got=%b exp=1", halt); end
    idle(); rx_valid = 1'b1; rx_data = 8'h22; step();
    idle(); rst = 1'b0; step();
    rst = 1'b1;
    checks++; if (halt !== 1'b0) begin failures++; $display("FAIL rst_halt got=%b exp=0", halt); end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL rst_tx got=%b exp=0", tx_valid); end
    bus_rd(3'd1); step();
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL rst_status got=%h exp=00", dout); end
    idle();
  endtask

  task automatic test_random();
    logic exp_stall;
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 199) != 0);
      rdy      = ($urandom_range(0, 9) != 0);
      en       = ($urandom_range(0, 2) != 0);
      wr       = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0, 1:    sel = 3'd0;
        2:       sel = 3'd1;
        3:       sel = 3'd4;
        default: sel = 3'($urandom);
      endcase
      din      = 8'($urandom);
      tx_ready = ($urandom_range(0, 3) == 0);
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_data  = 8'($urandom);
      #1;
      exp_stall = rst && rdy && en && wr && sel == 3'd0 && tx_q.size() == 16;
      checks++; if (stall !== exp_stall) begin failures++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, stall, exp_stall); end
      step();
      checks++; if (dout !== m_dout) begin failures++; $display("FAIL rnd_dout n=%0d got=%h exp=%h", n, dout, m_dout); end
      checks++; if (halt !== m_halt) begin failures++; $display("FAIL rnd_halt n=%0d got=%b exp=%b", n, halt, m_halt); end
      checks++; if (tx_valid !== (tx_q.size() != 0)) begin failures++; $display("FAIL rnd_txvalid n=%0d got=%b exp=%b", n, tx_valid, tx_q.size() != 0); end
      if (tx_q.size() != 0) begin
        checks++; if (tx_data !== tx_q[0]) begin failures++; $display("FAIL rnd_txdata n=%0d got=%h exp=%h", n, tx_data, tx_q[0]); end
      end
    end
    idle();
  endtask

  initial begin
    idle(); tx_ready = 1'b0; rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_tx_write();
    test_tx_full();
    test_rx_basic();
    test_rx_overflow();
    test_boundary();
    test_halt_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
